// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: decode handshake, redirect bus and IMEM port.
// The slave modport is the fetch stage itself; master is its environment.
interface if_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic        imem_re_o;
    logic [31:0] imem_data_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;

    modport slave (
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  imem_data_i,
        output imem_addr_o,
        output imem_re_o,
        output inst_o,
        output pc_o,
        output valid_o
    );

    modport master (
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        output imem_data_i,
        input  imem_addr_o,
        input  imem_re_o,
        input  inst_o,
        input  pc_o,
        input  valid_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency IMEM,
// absorbs decode stalls with a one-entry skid register and squashes
// wrong-path fetches on redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.slave   bus
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic [31:0] skid_q, skid_d;

    logic        re;
    logic        redir;
    logic [31:0] redir_tgt;

    // Redirect is ignored while reset is held so the IMEM port shows reset values.
    assign redir     = bus.redirect_i & rst_n;
    assign redir_tgt = {bus.redirect_pc_i[31:2], 2'b00};

    // Next-state and output decode; redirect outranks stall in every state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        skid_d     = skid_q;
        re         = 1'b0;
        bus.valid_o     = 1'b0;
        bus.inst_o      = NOP_INST;
        bus.pc_o        = rsp_pc_q;
        bus.imem_addr_o = fetch_pc_q;

        if (redir) begin
            re              = 1'b1;
            bus.imem_addr_o = redir_tgt;
            rsp_pc_d        = redir_tgt;
            fetch_pc_d      = redir_tgt + 32'd4;
            state_d         = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    re         = 1'b1;
                    rsp_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_RUN;
                end
                ST_RUN: begin
                    bus.valid_o = 1'b1;
                    bus.inst_o  = bus.imem_data_i;
                    if (bus.stall_i) begin
                        skid_d  = bus.imem_data_i;
                        state_d = ST_HOLD;
                    end else begin
                        re         = 1'b1;
                        rsp_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                ST_HOLD: begin
                    bus.valid_o = 1'b1;
                    bus.inst_o  = skid_q;
                    if (!bus.stall_i) begin
                        re         = 1'b1;
                        rsp_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end

        bus.imem_re_o = re & rst_n;
    end

    // Fetch-stage state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            skid_q     <= NOP_INST;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            skid_q     <= skid_d;
        end
    end

endmodule
